// File: rtl/hw_sw_byte_bridge.sv
`default_nettype none
// hw_sw_byte_bridge: four-phase byte handshake between NIOS PIOs and a block-based core.
// Rev 1.0 - initial release.
module hw_sw_byte_bridge #(
  parameter int IN_BYTES    = 32,
  parameter int OUT_BYTES   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [7:0]             to_hw_port,
  input  logic [1:0]             to_hw_sig,
  output logic [7:0]             to_sw_port,
  output logic [1:0]             to_sw_sig,
  output logic [IN_BYTES*8-1:0]  blk_data,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  input  logic [OUT_BYTES*8-1:0] res_data,
  input  logic                   res_valid,
  output logic                   res_ready,
  output logic                   busy
);

  localparam int RXW = (IN_BYTES > 1) ? $clog2(IN_BYTES) : 1;
  localparam int TXW = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [RXW-1:0] RX_LAST = RXW'(IN_BYTES - 1);
  localparam logic [TXW-1:0] TX_LAST = TXW'(OUT_BYTES - 1);

  typedef enum logic [2:0] {
    RX_IDLE, RX_ACK, SEND_BLK, WAIT_RES, TX_IDLE, TX_ACK, DONE, DONE_CLR
  } state_t;

  state_t               state;
  logic [RXW-1:0]       rx_cnt;
  logic [TXW-1:0]       tx_cnt;
  logic [OUT_BYTES*8-1:0] tx_buf;
  logic [1:0]           sync_q [SYNC_STAGES];
  logic [1:0]           sig_s;
  logic                 abort;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= to_hw_sig;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sig_s = sync_q[SYNC_STAGES-1];

  // Abort only applies while a byte exchange with software can be in progress.
  assign abort = (sig_s == 2'b11) &&
                 (state == RX_IDLE || state == RX_ACK || state == TX_IDLE || state == TX_ACK);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= RX_IDLE;
      rx_cnt     <= '0;
      tx_cnt     <= '0;
      tx_buf     <= '0;
      to_sw_port <= '0;
      to_sw_sig  <= 2'b00;
      blk_data   <= '0;
      blk_valid  <= 1'b0;
      res_ready  <= 1'b0;
      busy       <= 1'b0;
    end else if (abort) begin
      state     <= RX_IDLE;
      rx_cnt    <= '0;
      tx_cnt    <= '0;
      to_sw_sig <= 2'b00;
      busy      <= 1'b0;
    end else begin
      case (state)
        RX_IDLE: if (sig_s == 2'b01) begin
          blk_data[(IN_BYTES-1-int'(rx_cnt))*8 +: 8] <= to_hw_port;
          to_sw_sig <= 2'b01;
          busy      <= 1'b1;
          state     <= RX_ACK;
        end
        RX_ACK: if (sig_s == 2'b00) begin
          to_sw_sig <= 2'b00;
          if (rx_cnt == RX_LAST) begin
            blk_valid <= 1'b1;
            state     <= SEND_BLK;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
            busy   <= 1'b0;
            state  <= RX_IDLE;
          end
        end
        SEND_BLK: if (blk_ready) begin
          blk_valid <= 1'b0;
          res_ready <= 1'b1;
          state     <= WAIT_RES;
        end
        WAIT_RES: if (res_valid) begin
          tx_buf    <= res_data;
          res_ready <= 1'b0;
          tx_cnt    <= '0;
          state     <= TX_IDLE;
        end
        TX_IDLE: if (sig_s == 2'b10) begin
          to_sw_port <= tx_buf[(OUT_BYTES-1-int'(tx_cnt))*8 +: 8];
          to_sw_sig  <= 2'b10;
          state      <= TX_ACK;
        end
        TX_ACK: if (sig_s == 2'b00) begin
          if (tx_cnt == TX_LAST) begin
            to_sw_sig <= 2'b11;
            state     <= DONE;
          end else begin
            to_sw_sig <= 2'b00;
            tx_cnt    <= tx_cnt + 1'b1;
            state     <= TX_IDLE;
          end
        end
        DONE: if (sig_s == 2'b11) begin
          to_sw_sig <= 2'b00;
          state     <= DONE_CLR;
        end
        DONE_CLR: if (sig_s == 2'b00) begin
          rx_cnt <= '0;
          tx_cnt <= '0;
          busy   <= 1'b0;
          state  <= RX_IDLE;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hw_sw_byte_bridge.sv
`default_nettype none
// tb_hw_sw_byte_bridge: table-driven and randomized transfers against a transaction-level model.
// Rev 1.0 - initial release.
module tb_hw_sw_byte_bridge;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [7:0]   to_hw_port;
  logic [1:0]   to_hw_sig;
  logic [7:0]   to_sw_port;
  logic [1:0]   to_sw_sig;
  logic [255:0] blk_data;
  logic         blk_valid;
  logic         blk_ready;
  logic [127:0] res_data;
  logic         res_valid;
  logic         res_ready;
  logic         busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];

  typedef struct {
    logic [7:0]   base;
    logic [7:0]   step;
    logic [127:0] res;
    logic [255:0] exp_blk;
  } vec_t;
  vec_t vecs[3];

  hw_sw_byte_bridge #(.IN_BYTES(32), .OUT_BYTES(16), .SYNC_STAGES(2)) dut (
    .Clk(Clk), .Reset(Reset), .to_hw_port(to_hw_port), .to_hw_sig(to_hw_sig),
    .to_sw_port(to_sw_port), .to_sw_sig(to_sw_sig), .blk_data(blk_data),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .res_data(res_data),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Waits until to_sw_sig equals (or, with neq, differs from) e; returns cycles taken.
  task automatic wait_sig(input logic [1:0] e, input bit neq, input int maxc, output int n);
    bit hit;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
      hit = neq ? (to_sw_sig !== e) : (to_sw_sig === e);
    end while (!hit && n < maxc);
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL timeout_sig actual=%b waiting_for=%b neq=%0d", to_sw_sig, e, neq);
    end
  endtask

  function automatic logic [255:0] pack();
    logic [255:0] r = '0;
    for (int i = 0; i < q.size() && i < 32; i++) r[(31-i)*8 +: 8] = q[i];
    return r;
  endfunction

  task automatic write_byte(input logic [7:0] b);
    int n;
    to_hw_port = b;
    to_hw_sig  = 2'b01;
    wait_sig(2'b01, 1'b0, 20, n);
    chk("rx_ack_latency", 256'(n), 256'd3);
    to_hw_sig = 2'b00;
    wait_sig(2'b00, 1'b0, 20, n);
    q.push_back(b);
  endtask

  task automatic finish_block(input logic [255:0] exp_blk, input logic [127:0] res, input int bp);
    int n;
    chk("blk_valid", 256'(blk_valid), 256'd1);
    chk("blk_data", blk_data, exp_blk);
    for (int i = 0; i < bp; i++) begin
      @(negedge Clk);
      chk("bp_valid", 256'(blk_valid), 256'd1);
      chk("bp_data", blk_data, exp_blk);
    end
    blk_ready = 1'b1;
    @(negedge Clk);
    blk_ready = 1'b0;
    chk("blk_accept", 256'(blk_valid), 256'd0);
    chk("res_ready_set", 256'(res_ready), 256'd1);
    res_data  = res;
    res_valid = 1'b1;
    @(negedge Clk);
    res_valid = 1'b0;
    chk("res_ready_clr", 256'(res_ready), 256'd0);
    for (int i = 0; i < 16; i++) begin
      to_hw_sig = 2'b10;
      wait_sig(2'b10, 1'b0, 20, n);
      chk("tx_byte", 256'(to_sw_port), 256'(res[(15-i)*8 +: 8]));
      to_hw_sig = 2'b00;
      wait_sig(2'b10, 1'b1, 20, n);
      chk("tx_ack_sig", 256'(to_sw_sig), (i == 15) ? 256'd3 : 256'd0);
    end
    to_hw_sig = 2'b11;
    wait_sig(2'b00, 1'b0, 20, n);
    chk("done_busy", 256'(busy), 256'd1);
    to_hw_sig = 2'b00;
    repeat (4) @(negedge Clk);
    chk("idle_busy", 256'(busy), 256'd0);
    q.delete();
  endtask

  initial begin
    int n;
    logic [255:0] eb;
    logic [127:0] rr;
    Reset = 1'b1; to_hw_port = '0; to_hw_sig = 2'b00; blk_ready = 1'b0;
    res_data = '0; res_valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("rst_port", 256'(to_sw_port), 256'd0);
    chk("rst_sig", 256'(to_sw_sig), 256'd0);
    chk("rst_blk", blk_data, 256'd0);
    chk("rst_flags", 256'({blk_valid, res_ready, busy}), 256'd0);
    Reset = 1'b0;
    @(negedge Clk);

    vecs[0].base = 8'h00; vecs[0].step = 8'h01;
    vecs[0].res = 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF;
    vecs[0].exp_blk = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    vecs[1].base = 8'hFF; vecs[1].step = 8'h00;
    vecs[1].res = 128'h00112233445566778899AABBCCDDEEFF;
    vecs[1].exp_blk = {32{8'hFF}};
    vecs[2].base = 8'h80; vecs[2].step = 8'hFF;
    vecs[2].res = 128'h0F0E0D0C0B0A09080706050403020117;
    vecs[2].exp_blk = 256'h807F7E7D7C7B7A797877767574737271706F6E6D6C6B6A696867666564636261;

    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 32; i++) write_byte(vecs[v].base + 8'(i) * vecs[v].step);
      finish_block(vecs[v].exp_blk, vecs[v].res, (v == 0) ? 10 : v);
    end

    // Reset in the middle of a receive discards partial data.
    for (int i = 0; i < 5; i++) write_byte(8'h40 + 8'(i));
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    chk("mid_rst_port", 256'(to_sw_port), 256'd0);
    chk("mid_rst_sig", 256'(to_sw_sig), 256'd0);
    chk("mid_rst_blk", blk_data, 256'd0);
    chk("mid_rst_flags", 256'({blk_valid, res_ready, busy}), 256'd0);
    Reset = 1'b0;
    q.delete();
    @(negedge Clk);
    for (int i = 0; i < 32; i++) write_byte(8'($urandom));
    eb = pack();
    chk("rst_msb_slot", 256'(blk_data[255:248]), 256'(q[0]));
    finish_block(eb, {$urandom, $urandom, $urandom, $urandom}, 2);

    // Abort while byte 8 is awaiting its release.
    for (int i = 0; i < 7; i++) write_byte(8'($urandom));
    to_hw_port = 8'h99;
    to_hw_sig  = 2'b01;
    wait_sig(2'b01, 1'b0, 20, n);
    to_hw_sig = 2'b11;
    wait_sig(2'b00, 1'b0, 20, n);
    chk("abort_latency", 256'(n), 256'd3);
    chk("abort_busy", 256'(busy), 256'd0);
    to_hw_sig = 2'b00;
    repeat (4) @(negedge Clk);
    q.delete();
    for (int i = 0; i < 31; i++) write_byte(8'($urandom));
    chk("abort_cnt_reset", 256'(blk_valid), 256'd0);
    write_byte(8'($urandom));
    finish_block(pack(), {$urandom, $urandom, $urandom, $urandom}, 0);

    // Held command counts once; read request during receive is ignored.
    to_hw_port = 8'h5A;
    to_hw_sig  = 2'b01;
    wait_sig(2'b01, 1'b0, 20, n);
    repeat (20) @(negedge Clk);
    chk("hold_sig", 256'(to_sw_sig), 256'd1);
    chk("hold_busy", 256'(busy), 256'd1);
    to_hw_sig = 2'b00;
    wait_sig(2'b00, 1'b0, 20, n);
    q.push_back(8'h5A);
    to_hw_sig = 2'b10;
    repeat (10) @(negedge Clk);
    chk("ignore10_sig", 256'(to_sw_sig), 256'd0);
    chk("ignore10_busy", 256'(busy), 256'd0);
    to_hw_sig = 2'b00;
    repeat (4) @(negedge Clk);
    for (int i = 0; i < 30; i++) write_byte(8'($urandom));
    chk("abuse_not_full", 256'(blk_valid), 256'd0);
    write_byte(8'($urandom));
    finish_block(pack(), {$urandom, $urandom, $urandom, $urandom}, 1);

    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 32; i++) write_byte(8'($urandom));
      rr = {$urandom, $urandom, $urandom, $urandom};
      finish_block(pack(), rr, $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "global timeout");
  end

endmodule
`default_nettype wire
